// File: rtl/fadd_pkg.sv
// ---------------------------------------------------------------------------
// fadd_pkg
// Shared definitions for the arbitrated bf16 adder: the bf16 word width and
// field positions, and the records carried by the two pipeline stages.
// Ports: none (package).
// ---------------------------------------------------------------------------
package fadd_pkg;

    localparam int BF16_W   = 16;
    localparam int SIGN_BIT = 15;
    localparam int EXP_HI   = 14;
    localparam int EXP_LO   = 7;
    localparam int MAN_HI   = 6;
    localparam int MAN_LO   = 0;

    // Widest requester index (N_REQ up to 8); narrower builds use the low bits.
    localparam int ID_MAX_W = 3;

    localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;

    // S1: accepted operand pair plus the issuing requester.
    typedef struct packed {
        logic [BF16_W-1:0]   a;
        logic [BF16_W-1:0]   b;
        logic [ID_MAX_W-1:0] id;
    } s1_rec_t;

    // S2: finished sum waiting for the consumer.
    typedef struct packed {
        logic [BF16_W-1:0]   y;
        logic [ID_MAX_W-1:0] id;
    } s2_rec_t;

endpackage

// File: rtl/float_adder_bf16.sv
// ---------------------------------------------------------------------------
// float_adder_bf16
// Combinational bf16 adder, round-to-nearest-even. Subnormal inputs and
// results are flushed to zero; NaN inputs or inf-inf give a quiet NaN.
// Ports:
//   clock, reset : present for interface compatibility, unused (pure comb)
//   a, b         : bf16 operands
//   y            : bf16 sum a+b
// ---------------------------------------------------------------------------
module float_adder_bf16
    import fadd_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [BF16_W-1:0] a,
    input  logic [BF16_W-1:0] b,
    output logic [BF16_W-1:0] y
);

    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clock, reset};

    // m holds the 8-bit significand in [10:3], guard in [2], round/sticky in [1:0].
    function automatic logic [8:0] round_rne(input logic [10:0] m);
        logic inc;
        inc = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[10:3]} + {8'd0, inc};
    endfunction

    logic        sa, sb, s_big, s_sml, same;
    logic [7:0]  ea, eb, e_big, e_sml, d;
    logic [10:0] ma, mb, m_big, m_sml, m_al, norm;
    logic [21:0] sh;
    logic [11:0] sum;
    logic [9:0]  e_res, e_fin;
    logic [3:0]  lz;
    logic        found;
    logic [8:0]  rnd;
    logic        a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        sa    = a[SIGN_BIT];
        sb    = b[SIGN_BIT];
        ea    = a[EXP_HI:EXP_LO];
        eb    = b[EXP_HI:EXP_LO];
        ma    = (ea == 8'd0) ? 11'd0 : {1'b1, a[MAN_HI:MAN_LO], 3'b000};
        mb    = (eb == 8'd0) ? 11'd0 : {1'b1, b[MAN_HI:MAN_LO], 3'b000};
        a_nan = (ea == 8'hFF) && (a[MAN_HI:MAN_LO] != 7'd0);
        b_nan = (eb == 8'hFF) && (b[MAN_HI:MAN_LO] != 7'd0);
        a_inf = (ea == 8'hFF) && (a[MAN_HI:MAN_LO] == 7'd0);
        b_inf = (eb == 8'hFF) && (b[MAN_HI:MAN_LO] == 7'd0);

        // Order by magnitude so the subtraction below never goes negative.
        if (a[EXP_HI:MAN_LO] >= b[EXP_HI:MAN_LO]) begin
            s_big = sa; e_big = ea; m_big = ma;
            s_sml = sb; e_sml = eb; m_sml = mb;
        end else begin
            s_big = sb; e_big = eb; m_big = mb;
            s_sml = sa; e_sml = ea; m_sml = ma;
        end
        same = (s_big == s_sml);

        // Align the smaller operand; everything shifted out folds into sticky.
        d    = e_big - e_sml;
        sh   = {m_sml, 11'd0} >> d;
        m_al = {sh[21:12], sh[11] | (|sh[10:0])};

        sum = same ? ({1'b0, m_big} + {1'b0, m_al}) : ({1'b0, m_big} - {1'b0, m_al});

        lz    = 4'd0;
        found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!found && sum[i]) begin
                found = 1'b1;
                lz    = 4'(10 - i);
            end
        end

        if (sum[11]) begin
            norm  = {sum[11:2], sum[1] | sum[0]};
            e_res = {2'b00, e_big} + 10'd1;
        end else begin
            norm  = sum[10:0] << lz;
            e_res = {2'b00, e_big} - {6'd0, lz};
        end

        rnd   = round_rne(norm);
        e_fin = e_res + {9'd0, rnd[8]};

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y = BF16_QNAN;
        end else if (a_inf) begin
            y = {sa, 8'hFF, 7'd0};
        end else if (b_inf) begin
            y = {sb, 8'hFF, 7'd0};
        end else if (sum == 12'd0 || (!sum[11] && (e_res[9] || e_res == 10'd0))) begin
            // Exact cancellation is +0; like-signed zeros keep their sign.
            y = {same & s_big, 15'd0};
        end else if (e_fin >= 10'd255) begin
            y = {s_big, 8'hFF, 7'd0};
        end else begin
            y = {s_big, e_fin[7:0], rnd[8] ? rnd[7:1] : rnd[6:0]};
        end
    end

endmodule

// File: rtl/fadd_arb_bf16.sv
// ---------------------------------------------------------------------------
// fadd_arb_bf16
// N_REQ requesters share one bf16 adder through a round-robin arbiter and a
// two-stage pipeline (S1 operands, S2 result). Results leave in acceptance
// order tagged with the requester index; rsp_ready backpressure stalls the
// pipeline and closes the grant.
// Optional feature: define FADD_ARB_STATS_EN to add per-requester
// saturating 16-bit transfer counters on grant_count.
// Ports:
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   req_valid[i] : requester i presents an operand pair
//   req_ready[i] : requester i is accepted this cycle (one-hot or zero)
//   req_a, req_b : bf16 operands, 16-bit slice i per requester
//   rsp_valid    : result available
//   rsp_ready    : consumer accepts result
//   rsp_y        : bf16 sum
//   rsp_id       : index of the requester that issued the result
//   grant_count  : (FADD_ARB_STATS_EN only) 16-bit counter per requester
// ---------------------------------------------------------------------------
module fadd_arb_bf16
    import fadd_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*BF16_W-1:0] req_a,
    input  logic [N_REQ*BF16_W-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BF16_W-1:0]       rsp_y,
    output logic [ID_W-1:0]         rsp_id
`ifdef FADD_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]     grant_count
`endif
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic              vld_p1, vld_p2;
    logic              drain_p2, adv_p1, open_p1, xfer;
    s1_rec_t           st_p1;
    s2_rec_t           st_p2;
    logic [BF16_W-1:0] sum_p1;

    // Round-robin search starting at rr_ptr; index arithmetic wraps because
    // N_REQ is a power of two.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = rr_ptr;
        idx     = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign drain_p2  = vld_p2 & rsp_ready;
    assign adv_p1    = vld_p1 & (~vld_p2 | drain_p2);
    assign open_p1   = ~vld_p1 | adv_p1;
    // Gating with reset keeps req_ready low for the whole reset assertion.
    assign xfer      = gnt_any & open_p1 & reset;
    assign req_ready = xfer ? (N_REQ'(1) << gnt_id) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (xfer) begin
                rr_ptr <= gnt_id + ID_W'(1);
            end
            if (xfer) begin
                vld_p1 <= 1'b1;
            end else if (adv_p1) begin
                vld_p1 <= 1'b0;
            end
            if (adv_p1) begin
                vld_p2 <= 1'b1;
            end else if (drain_p2) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    // ---- stage S1: accepted operands ----
    always_ff @(posedge clock) begin
        if (xfer) begin
            st_p1.a  <= req_a[gnt_id*BF16_W +: BF16_W];
            st_p1.b  <= req_b[gnt_id*BF16_W +: BF16_W];
            st_p1.id <= ID_MAX_W'(gnt_id);
        end
    end

    float_adder_bf16 u_add (
        .clock (clock),
        .reset (1'b1),
        .a     (st_p1.a),
        .b     (st_p1.b),
        .y     (sum_p1)
    );

    // ---- stage S2: registered result ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_p2 <= '0;
        end else if (adv_p1) begin
            st_p2.y  <= sum_p1;
            st_p2.id <= st_p1.id;
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_y     = st_p2.y;
    assign rsp_id    = st_p2.id[ID_W-1:0];

    // Upper id bits only carry information in the widest configuration.
    logic unused_id_hi;
    assign unused_id_hi = &{1'b0, st_p2.id};

`ifdef FADD_ARB_STATS_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (xfer && gnt_id == ID_W'(g) && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_count[g*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_fadd_arb_bf16.sv
module tb_fadd_arb_bf16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic [1:0]  rsp_id;
`ifdef FADD_ARB_STATS_EN
    logic [63:0] grant_count;
`endif

    fadd_arb_bf16 #(.N_REQ(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
`ifdef FADD_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  id;
        logic [15:0] y;
    } vec_t;

    localparam int NV = 11;
    vec_t        vt[NV];
    logic [15:0] rr_a[4];
    logic [15:0] rr_y[4];

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 4'b0000;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic set_rr_operands();
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = rr_a[i];
            req_b[i*16 +: 16] = 16'h3F80;
        end
    endtask

    // One isolated request; checks grant, t+1 empty, t+2 result.
    task automatic single_op(input int vi);
        int n;
        @(posedge clock); #1;
        req_a[vt[vi].id*16 +: 16] = vt[vi].a;
        req_b[vt[vi].id*16 +: 16] = vt[vi].b;
        req_valid = 4'b0001 << vt[vi].id;
        n = 0;
        @(negedge clock);
        while (req_ready == 4'b0000 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("vec%0d_ready", vi), {28'd0, req_ready}, 32'(4'b0001 << vt[vi].id));
        @(posedge clock); #1;
        req_valid = 4'b0000;
        @(negedge clock);
        chk($sformatf("vec%0d_valid_t1", vi), {31'd0, rsp_valid}, 32'd0);
        @(negedge clock);
        chk($sformatf("vec%0d_valid_t2", vi), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("vec%0d_y", vi), {16'd0, rsp_y}, {16'd0, vt[vi].y});
        chk($sformatf("vec%0d_id", vi), {30'd0, rsp_id}, {30'd0, vt[vi].id});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcount, rcount, ngr;
        logic [3:0] granted;

        //            a         b         id    y
        vt[0]  = '{16'h3F80, 16'h4000, 2'd2, 16'h4040};  // 1+2
        vt[1]  = '{16'h3F80, 16'hBF80, 2'd1, 16'h0000};  // 1-1
        vt[2]  = '{16'h3F80, 16'h3F80, 2'd0, 16'h4000};  // 1+1
        vt[3]  = '{16'h4000, 16'h4000, 2'd3, 16'h4080};  // 2+2
        vt[4]  = '{16'h4040, 16'hBF80, 2'd0, 16'h4000};  // 3-1
        vt[5]  = '{16'h0000, 16'h3F80, 2'd1, 16'h3F80};  // 0+1
        vt[6]  = '{16'h7F80, 16'h3F80, 2'd2, 16'h7F80};  // inf+1
        vt[7]  = '{16'hC000, 16'h3F80, 2'd3, 16'hBF80};  // -2+1
        vt[8]  = '{16'h3F80, 16'h3B80, 2'd0, 16'h3F80};  // tie, rounds to even
        vt[9]  = '{16'h3F81, 16'h3B80, 2'd1, 16'h3F82};  // tie, rounds up to even
        vt[10] = '{16'h7F7F, 16'h7F7F, 2'd2, 16'h7F80};  // overflow to inf

        rr_a[0] = 16'h3F80; rr_y[0] = 16'h4000;
        rr_a[1] = 16'h4000; rr_y[1] = 16'h4040;
        rr_a[2] = 16'h4040; rr_y[2] = 16'h4080;
        rr_a[3] = 16'h4080; rr_y[3] = 16'h40A0;

        // Reset state, with every requester asking.
        reset     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_y", {16'd0, rsp_y}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            single_op(i);
        end

        // All four requesters streaming.
        do_reset();
        set_rr_operands();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (k < 6) chk($sformatf("rr_grant%0d", k), {28'd0, req_ready}, 32'(4'b0001 << (k % 4)));
            if (k >= 2) begin
                chk($sformatf("rr_valid%0d", k), {31'd0, rsp_valid}, 32'd1);
                chk($sformatf("rr_id%0d", k), {30'd0, rsp_id}, 32'((k - 2) % 4));
                chk($sformatf("rr_y%0d", k), {16'd0, rsp_y}, {16'd0, rr_y[(k - 2) % 4]});
            end else begin
                chk($sformatf("rr_valid%0d", k), {31'd0, rsp_valid}, 32'd0);
            end
            @(posedge clock); #1;
            if (k == 5) req_valid = 4'b0000;
        end

        // Consumer stalls for 5 cycles under a continuous stream.
        do_reset();
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 4'hF;
        ngr = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (req_ready != 4'b0000) ngr++;
            if (k < 2) begin
                chk($sformatf("stall_grant%0d", k), {28'd0, req_ready}, 32'(4'b0001 << k));
            end else begin
                chk($sformatf("stall_ready%0d", k), {28'd0, req_ready}, 32'd0);
                chk($sformatf("stall_valid%0d", k), {31'd0, rsp_valid}, 32'd1);
                chk($sformatf("stall_id%0d", k), {30'd0, rsp_id}, 32'd0);
                chk($sformatf("stall_y%0d", k), {16'd0, rsp_y}, {16'd0, rr_y[0]});
            end
            @(posedge clock); #1;
            if (k == 4) rsp_ready = 1'b1;
        end
        chk("stall_transfers", ngr, 32'd2);
        gcount = ngr;
        rcount = 0;
        for (int c = 0; c < 40 && !(gcount == 10 && rcount == 10); c++) begin
            @(negedge clock);
            if (req_ready != 4'b0000) begin
                chk($sformatf("resume_grant%0d", gcount), {28'd0, req_ready}, 32'(4'b0001 << (gcount % 4)));
                gcount++;
            end
            if (rsp_valid && rsp_ready) begin
                chk($sformatf("resume_id%0d", rcount), {30'd0, rsp_id}, 32'(rcount % 4));
                chk($sformatf("resume_y%0d", rcount), {16'd0, rsp_y}, {16'd0, rr_y[rcount % 4]});
                rcount++;
            end
            @(posedge clock); #1;
            if (gcount >= 10) req_valid = 4'b0000;
        end
        chk("resume_grants", gcount, 32'd10);
        chk("resume_results", rcount, 32'd10);

        // Reset with two operations in flight.
        do_reset();
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 4'b1100;
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        gcount = 0;
        rcount = 0;
        for (int k = 0; k < 10; k++) begin
            granted = req_ready;
            if (req_ready != 4'b0000) begin
                chk($sformatf("postrst_grant%0d", gcount), {28'd0, req_ready}, 32'(4'b0001 << gcount));
                gcount++;
            end
            if (rsp_valid) begin
                if (rcount < 2) begin
                    chk($sformatf("postrst_id%0d", rcount), {30'd0, rsp_id}, 32'(rcount));
                    chk($sformatf("postrst_y%0d", rcount), {16'd0, rsp_y}, {16'd0, rr_y[rcount]});
                end
                rcount++;
            end
            @(posedge clock); #1;
            req_valid = req_valid & ~granted;
            @(negedge clock);
        end
        chk("postrst_grants", gcount, 32'd2);
        chk("postrst_results", rcount, 32'd2);

`ifdef FADD_ARB_STATS_EN
        begin
            int cnt[4];
            logic [15:0] exp_cnt;
            do_reset();
            rsp_ready = 1'b1;
            for (int i = 0; i < 4; i++) cnt[i] = 0;
            @(posedge clock); #1;
            req_valid = 4'b0101;
            for (int c = 0; c < 70010; c++) begin
                @(negedge clock);
                for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
                @(posedge clock); #1;
                if (c == 5) req_valid = 4'b0010;
            end
            req_valid = 4'b0000;
            repeat (4) @(negedge clock);
            chk("stats_req1_total", {31'd0, cnt[1] >= 70000}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                exp_cnt = (cnt[i] > 65535) ? 16'hFFFF : 16'(cnt[i]);
                chk($sformatf("stats_cnt%0d", i), {16'd0, grant_count[i*16 +: 16]}, {16'd0, exp_cnt});
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fadd_arb_bf16.md
FADD_ARB_BF16 -- requirements
Module: fadd_arb_bf16

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (power of two, 2..8).
REQ-002 SHALL have localparam ID_W = clog2(N_REQ), the requester index width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester operand pair valid.
REQ-006 SHALL have port req_ready, output, N_REQ, per-requester accept (one-hot or zero).
REQ-007 SHALL have port req_a, input, N_REQ*16, bf16 operand A; slice i belongs to requester i.
REQ-008 SHALL have port req_b, input, N_REQ*16, bf16 operand B; slice i belongs to requester i.
REQ-009 SHALL have port rsp_valid, output, 1, result available.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port rsp_y, output, 16, bf16 sum A+B.
REQ-012 SHALL have port rsp_id, output, ID_W, index of the requester that issued the result.

Function
REQ-013 SHALL share one bf16 adder among all requesters; a transfer occurs on requester i when req_valid[i] & req_ready[i].
REQ-014 SHALL grant round-robin: highest priority goes to index rr_ptr, then rr_ptr+1 ... wrapping modulo N_REQ.
REQ-015 SHALL set rr_ptr to (granted index + 1) mod N_REQ only on a transfer; with no transfer rr_ptr holds.
REQ-016 SHALL assert req_ready only for the granted requester, and only when stage S1 is empty or S1 advances this cycle.
REQ-017 SHALL register operands and id into S1 on transfer; S1 advances into S2 when S2 is empty or S2 drains this cycle.
REQ-018 SHALL compute the S2 result combinationally from S1 operands via the adder, registering y and id into S2.
REQ-019 SHALL drive rsp_valid from S2 occupancy; S2 drains when rsp_valid & rsp_ready.
REQ-020 SHALL give latency: transfer in cycle t -> rsp_valid in cycle t+2, with rsp_ready held high.
REQ-021 SHALL sustain one transfer per cycle while rsp_ready is high.
REQ-022 SHALL handle a cycle with drain, S1 advance and new transfer all at once with no loss or duplication.
REQ-023 SHALL hold rsp_y and rsp_id stable while rsp_valid=1 and rsp_ready=0; at most 2 operations in flight.
REQ-024 SHALL return results in acceptance order.
REQ-025 SHALL NOT let a requester withdraw req_valid or change its operands before transfer; the bench checks this, not the RTL.

Reset
REQ-026 SHALL, while reset=0, clear S1/S2 occupancy, set rr_ptr=0, and drive rsp_valid=0 and req_ready=0 immediately (asynchronous).
REQ-027 SHALL drop operations in flight when reset is asserted mid-operation, with no result emitted.
REQ-028 SHALL reset rsp_y and rsp_id to 0.
REQ-029 SHALL make the first grant after reset release go to requester 0 if it is valid.

Configuration
REQ-030 SHALL, when macro FADD_ARB_STATS_EN is defined, add output grant_count (N_REQ*16): per-requester 16-bit transfer counters, saturating at 0xFFFF, cleared by reset.
REQ-031 SHALL, when FADD_ARB_STATS_EN is undefined, omit the grant_count port and its counters; all other behaviour is identical.

Structure
REQ-032 SHALL keep BF16_W=16, the bf16 field constants (sign 15, exp 14:7, man 6:0) and the S1/S2 stage record typedef in shared package fadd_pkg.
REQ-033 SHALL instantiate the existing combinational bf16 adder float_adder_bf16 once as the only sub-module, with its clock tied to clock and its reset tied inactive.

Verification
REQ-034 SHALL test a single request on id 2, a=0x3F80, b=0x4000, rsp_ready=1 -> rsp_y=0x4040, rsp_id=2, rsp_valid exactly 2 cycles after the transfer.
REQ-035 SHALL test all 4 req_valid held high with rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one result per cycle in that id order.
REQ-036 SHALL test a continuous stream with rsp_ready=0 for 5 cycles -> 2 transfers then all req_ready=0, rsp_y/rsp_id stable; on resume no results are lost or repeated.
REQ-037 SHALL test a=0x3F80, b=0xBF80 -> rsp_y=0x0000; a=0x3F80, b=0x3F80 -> rsp_y=0x4000.
REQ-038 SHALL test reset driven low with 2 operations in flight -> rsp_valid=0 at once; after release, requesters 1 and 0 both valid -> requester 0 is granted first and no stale result appears.
REQ-039 SHALL test, with FADD_ARB_STATS_EN, 70000 transfers on requester 1 -> grant_count[1]=0xFFFF, other counters equal their own transfer totals.
